// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider with a glitch-free runtime ratio update
// through a one-deep valid/ready slot, plus a stop that always completes its period.
module clk_div_gen #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         running,
  output logic [W-1:0] cur_div
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         full_q, full_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;

  logic         accept;
  logic         legal;
  logic         last;
  logic [W-1:0] cnt_inc;

  // High phase is the ceiling half, so odd ratios lean high.
  function automatic logic [W-1:0] hi_of(input logic [W-1:0] d);
    return d - (d >> 1);
  endfunction

  assign accept  = cfg_valid && !full_q;
  assign legal   = (cfg_div >= TWO);
  assign last    = (cnt_q == (div_q - ONE));
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    full_d  = full_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    err_d   = accept && !legal;

    unique case (state_q)
      IDLE: begin
        // A value left pending by a stop is flushed here so the slot frees up.
        if (full_q) begin
          div_d  = pend_q;
          full_d = 1'b0;
        end else if (accept && legal) begin
          div_d = cfg_div;
        end
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (accept && legal) begin
          pend_d = cfg_div;
          full_d = 1'b1;
        end
        if (!last) begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < hi_of(div_q));
        end else begin
          if (full_q) begin
            div_d  = pend_q;
            full_d = 1'b0;
          end
          cnt_d = '0;
          if (en) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      pend_q  <= '0;
      full_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = !full_q;
  assign cfg_err   = err_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign running   = (state_q == RUN);
  assign cur_div   = div_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: period-level reference model feeding a scoreboard queue,
// with a negedge monitor comparing every cycle and measuring each period.
module tb_clk_div_gen;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready, cfg_err, clk_out, tick, running;
  logic [W-1:0] cur_div;

  clk_div_gen #(.W(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick),
    .running(running), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         co;
    logic         tk;
    logic         run;
    logic         rdy;
    logic         err;
    logic [W-1:0] div;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: whole periods are laid out as a list of output bits.
  int m_div;
  int m_pend;
  bit m_full;
  bit m_run;
  bit wave[$];

  task automatic model_step();
    exp_t e;
    bit acc, lg, tk, co;
    int hi;
    acc = cfg_valid && !m_full;
    lg  = (cfg_div >= 2);
    tk  = 0;
    if (wave.size() > 0) begin
      co = wave.pop_front();
      if (acc && lg) begin m_pend = cfg_div; m_full = 1; end
    end else begin
      if (m_run) begin
        if (m_full) begin m_div = m_pend; m_full = 0; end
        if (acc && lg) begin m_pend = cfg_div; m_full = 1; end
      end else begin
        if (m_full) begin m_div = m_pend; m_full = 0; end
        else if (acc && lg) m_div = cfg_div;
      end
      if (en) begin
        hi = (m_div + 1) / 2;
        for (int i = 0; i < m_div; i++) wave.push_back(i < hi);
        co = wave.pop_front();
        tk = 1;
        m_run = 1;
      end else begin
        co = 0;
        m_run = 0;
      end
    end
    e.co  = co;
    e.tk  = tk;
    e.run = m_run;
    e.rdy = !m_full;
    e.err = acc && !lg;
    e.div = W'(m_div);
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_div = DEF; m_full = 0; m_run = 0;
      wave.delete();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor plus rise-to-rise period / high-time measurement.
  initial begin
    exp_t e;
    bit   prev_co, armed;
    int   per, hi, rdiv;
    prev_co = 0; armed = 0; per = 0; hi = 0; rdiv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_clk_out", clk_out, 0);
        chk("rst_running", running, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cur_div", cur_div, DEF);
        prev_co = 0; armed = 0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clk_out", clk_out, e.co);
        chk("tick", tick, e.tk);
        chk("running", running, e.run);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("cfg_err", cfg_err, e.err);
        chk("cur_div", cur_div, e.div);
        if (e.co && !prev_co) begin
          if (armed) begin
            chk("period", per, rdiv);
            chk("high_time", hi, (rdiv + 1) / 2);
          end
          armed = 1; rdiv = e.div; per = 0; hi = 0;
        end
        if (!e.run) armed = 0;
        per++;
        if (e.co) hi++;
        prev_co = e.co;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int d);
    bit r, ok;
    ok = 0;
    cfg_valid = 1'b1;
    cfg_div   = W'(d);
    for (int i = 0; i < 2000; i++) begin
      r = cfg_ready;
      @(negedge clk);
      if (r) begin ok = 1; break; end
    end
    cfg_valid = 1'b0;
    chk("cfg_accept_timeout", ok, 1);
  endtask

  task automatic wait_tick_div(input int d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tick && cur_div == W'(d)) begin ok = 1; break; end
    end
    chk("tick_wait_timeout", ok, 1);
  endtask

  initial begin
    bit rdy_prev;
    int r;
    cyc(3);
    rst = 1'b0;
    // 1: default ratio
    en = 1'b1;
    cyc(20);
    // 2: change to 3 mid-period
    cyc(1);
    offer(3);
    cyc(15);
    // 3: stop during high phase of 6, then restart
    offer(6);
    wait_tick_div(6);
    en = 1'b0;
    cyc(15);
    en = 1'b1;
    cyc(12);
    // 4: illegal ratios
    offer(0);
    offer(1);
    cyc(10);
    // 5: back-to-back updates
    offer(5);
    offer(7);
    cyc(30);
    // 6: async reset mid-high of 255
    en = 1'b0;
    cyc(20);
    offer(255);
    en = 1'b1;
    cyc(50);
    #3 rst = 1'b1;
    #1;
    chk("async_clk_out", clk_out, 0);
    chk("async_tick", tick, 0);
    chk("async_running", running, 0);
    chk("async_cfg_ready", cfg_ready, 1);
    chk("async_cfg_err", cfg_err, 0);
    chk("async_cur_div", cur_div, DEF);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    // randomized traffic
    rdy_prev = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cfg_valid && rdy_prev) cfg_valid = 1'b0;
      if (!cfg_valid && $urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1;
        r = $urandom_range(0, 19);
        if (r == 0) cfg_div = W'($urandom_range(0, 1));
        else if (r == 1) cfg_div = W'($urandom_range(13, 40));
        else cfg_div = W'($urandom_range(2, 12));
      end
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cyc(2);
        rst = 1'b0;
      end
      rdy_prev = cfg_ready;
    end
    cfg_valid = 1'b0;
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
